// File: rtl/mem_interface.sv
// -----------------------------------------------------------------------------
// mem_interface
//
// Memory interface stage between the datapath bus and a 512x32 asynchronous
// RAM. Holds MAR/MDR and turns single-cycle read/write commands into stable,
// registered RAM strobes. Read data is captured into MDR, and each access ends
// with a one-cycle done pulse.
//
// Handshake: a command (cmd_rd or cmd_wr) is accepted only when it is sampled
// in IDLE with exactly one of the two asserted. Any other command (both
// together, or any command while busy) is dropped and answered with a
// one-cycle cmd_err pulse on the following cycle. busy is high from the
// accepting edge until the edge that returns the block to IDLE.
//
// Ports
//   clock        rising-edge clock
//   clear        asynchronous active-high reset
//   MARin        load MAR from BusMuxOut[8:0] (IDLE only)
//   MDRin        load MDR from BusMuxOut (IDLE only)
//   cmd_rd       start a read at MAR (single-cycle pulse)
//   cmd_wr       start a write of MDR to MAR (single-cycle pulse)
//   BusMuxOut    datapath bus
//   Mdatain      RAM read data
//   ram_read     registered RAM read strobe
//   ram_write    registered RAM write strobe
//   ram_address  current MAR
//   ram_wdata    current MDR
//   MDRout_data  current MDR, to the bus mux
//   busy         high in ACCESS and DONE
//   done         one-cycle completion pulse
//   cmd_err      one-cycle rejected-command pulse
//   state_dbg    current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
// -----------------------------------------------------------------------------
module mem_interface #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        cmd_rd,
    input  logic        cmd_wr,
    input  logic [31:0] BusMuxOut,
    input  logic [31:0] Mdatain,
    output logic        ram_read,
    output logic        ram_write,
    output logic [8:0]  ram_address,
    output logic [31:0] ram_wdata,
    output logic [31:0] MDRout_data,
    output logic        busy,
    output logic        done,
    output logic        cmd_err,
    output logic [1:0]  state_dbg
);

    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("mem_interface: WAIT_CYCLES must be in 0..15");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    state_t      state_q;
    op_t         op_q;
    logic [3:0]  cnt_q;
    logic [8:0]  mar_q;
    logic [31:0] mdr_q;
    logic        rd_q;
    logic        wr_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    // Every output is a flop, so nothing combinational runs from the
    // command inputs to the RAM strobes. The strobes are set on the
    // accepting edge and cleared on the edge that enters DONE, giving
    // WAIT_CYCLES+1 cycles of strobe.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            op_q    <= OP_READ;
            cnt_q   <= 4'd0;
            mar_q   <= 9'd0;
            mdr_q   <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Register loads and an accepted command may share a
                    // cycle; the access then sees the new MAR/MDR because
                    // the strobe only rises at this same edge.
                    if (MARin) mar_q <= BusMuxOut[8:0];
                    if (MDRin) mdr_q <= BusMuxOut;
                    if (cmd_rd && cmd_wr) begin
                        err_q <= 1'b1;
                    end else if (cmd_rd || cmd_wr) begin
                        op_q    <= cmd_wr ? OP_WRITE : OP_READ;
                        cnt_q   <= CNT_INIT;
                        rd_q    <= cmd_rd;
                        wr_q    <= cmd_wr;
                        busy_q  <= 1'b1;
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // MAR/MDR are frozen here so address and write data
                    // stay stable for the whole strobe.
                    if (cmd_rd || cmd_wr) err_q <= 1'b1;
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (op_q == OP_READ) mdr_q <= Mdatain;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (cmd_rd || cmd_wr) err_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_read    = rd_q;
    assign ram_write   = wr_q;
    assign ram_address = mar_q;
    assign ram_wdata   = mdr_q;
    assign MDRout_data = mdr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cmd_err     = err_q;
    assign state_dbg   = state_q;

endmodule
